cvm300_frame_emulator: RTL and testbench

CVM300_FRAME_EMULATOR -- requirements
Module: cvm300_frame_emulator

---
 rtl/cvm300_frame_emulator.sv | 175 +++++++++++++++++
 tb/tb_cvm300_frame_emulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cvm300_frame_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : cvm300_frame_emulator
//  Description : CMOS sensor frame emulator. A rising edge on FRAME_REQ
//                starts one frame: a frame-overhead wait, then NUM_LINES lines
//                of LINE_PIXELS test-pattern pixels separated by LINE_GAP idle
//                cycles. Requests that arrive mid-frame are dropped and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module cvm300_frame_emulator #(
    parameter int LINE_PIXELS = 648,
    parameter int NUM_LINES   = 488,
    parameter int LINE_GAP    = 8,
    parameter int FOT_CYCLES  = 17
) (
    input  logic        CLK_IN,
    input  logic        SYS_RES_N,
    input  logic        FRAME_REQ,
    input  logic [1:0]  PATTERN_SEL,
    output logic [9:0]  D,
    output logic        Data_valid,
    output logic        Line_valid,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic        req_missed
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FOT  = 2'd1,
        S_LINE = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Row/column counters are 12 bits (max 4095), wait counter 8 bits (max 255)
    localparam logic [11:0] c_last_col = 12'(LINE_PIXELS - 1);
    localparam logic [11:0] c_last_row = 12'(NUM_LINES - 1);
    localparam logic [7:0]  c_fot_load = 8'(FOT_CYCLES);
    localparam logic [7:0]  c_gap_load = 8'(LINE_GAP - 1);

    state_t      r_state;
    logic        r_req_q;
    logic        r_armed;
    logic [1:0]  r_pattern;
    logic [11:0] r_row;
    logic [11:0] r_col;
    logic [7:0]  r_wait;
    logic [9:0]  r_d;
    logic        r_dval;
    logic        r_lval;
    logic        r_busy;
    logic [15:0] r_fcnt;
    logic        r_missed;

    logic        w_edge;
    logic [9:0]  w_col_lo_next;

    // Pixel value for a given pattern, row and column (all mod 1024)
    function automatic logic [9:0] f_pixel(
        input logic [1:0] pat,
        input logic [9:0] row_lo,
        input logic [9:0] col_lo,
        input logic [9:0] fc_lo
    );
        logic [9:0] v;
        case (pat)
            2'd0:    v = row_lo + col_lo;
            2'd1:    v = col_lo;
            2'd2:    v = fc_lo;
            default: v = col_lo[0] ? 10'h000 : 10'h3FF;
        endcase
        return v;
    endfunction

    // r_armed blocks a request that was already high when reset released:
    // an edge only counts once a low level has been seen since reset.
    assign w_edge        = FRAME_REQ & ~r_req_q & r_armed;
    assign w_col_lo_next = r_col[9:0] + 10'd1;

    // Request sampling for edge detection
    always_ff @(posedge CLK_IN) begin
        if (!SYS_RES_N) begin
            r_req_q <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_req_q <= FRAME_REQ;
            r_armed <= r_armed | ~FRAME_REQ;
        end
    end

    // Frame sequencer with registered video outputs
    always_ff @(posedge CLK_IN) begin
        if (!SYS_RES_N) begin
            r_state   <= S_IDLE;
            r_pattern <= 2'd0;
            r_row     <= 12'd0;
            r_col     <= 12'd0;
            r_wait    <= 8'd0;
            r_d       <= 10'd0;
            r_dval    <= 1'b0;
            r_lval    <= 1'b0;
            r_busy    <= 1'b0;
            r_fcnt    <= 16'd0;
            r_missed  <= 1'b0;
        end else begin
            // busy stays high for the first IDLE cycle after a frame, so an
            // edge landing there is also counted as missed.
            if (w_edge && (r_state != S_IDLE || r_busy)) begin
                r_missed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_d    <= 10'd0;
                    r_dval <= 1'b0;
                    r_lval <= 1'b0;
                    if (w_edge && !r_busy) begin
                        r_state   <= S_FOT;
                        r_pattern <= PATTERN_SEL;
                        r_wait    <= c_fot_load;
                        r_row     <= 12'd0;
                        r_col     <= 12'd0;
                        r_busy    <= 1'b1;
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end

                S_FOT, S_GAP: begin
                    if (r_wait == 8'd0) begin
                        r_state <= S_LINE;
                        r_col   <= 12'd0;
                        r_lval  <= 1'b1;
                        r_dval  <= 1'b1;
                        r_d     <= f_pixel(r_pattern, r_row[9:0], 10'd0, r_fcnt[9:0]);
                    end else begin
                        r_wait  <= r_wait - 8'd1;
                    end
                end

                S_LINE: begin
                    if (r_col == c_last_col) begin
                        r_lval <= 1'b0;
                        r_dval <= 1'b0;
                        r_d    <= 10'd0;
                        if (r_row == c_last_row) begin
                            r_state <= S_IDLE;
                            r_fcnt  <= r_fcnt + 16'd1;
                        end else begin
                            r_state <= S_GAP;
                            r_row   <= r_row + 12'd1;
                            r_wait  <= c_gap_load;
                        end
                    end else begin
                        r_col <= r_col + 12'd1;
                        r_d   <= f_pixel(r_pattern, r_row[9:0], w_col_lo_next, r_fcnt[9:0]);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign D           = r_d;
    assign Data_valid  = r_dval;
    assign Line_valid  = r_lval;
    assign busy        = r_busy;
    assign frame_count = r_fcnt;
    assign req_missed  = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_cvm300_frame_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cvm300_frame_emulator
//  Description : Directed self-checking bench for cvm300_frame_emulator.
//                Main instance: 4 pixels x 2 lines, gap 2, overhead 3.
//                Second instance: 1x1 frames for frame counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cvm300_frame_emulator;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [1:0]  pat;
    logic [9:0]  d_out;
    logic        dval;
    logic        lval;
    logic        bsy;
    logic [15:0] fcnt;
    logic        missed;

    logic        req_s;
    logic [9:0]  d_s;
    logic        dval_s;
    logic        lval_s;
    logic        bsy_s;
    logic [15:0] fcnt_s;
    logic        missed_s;

    int checks;
    int errors;

    logic        cap_lv [1:20];
    logic        cap_dv [1:20];
    logic [9:0]  cap_d  [1:20];
    logic        cap_bz [1:20];
    logic [15:0] cap_fc [1:20];

    // Hand-derived D per sampled cycle after the request (index 1 = first
    // cycle after the edge is taken), pattern 0 and pattern 3.
    int exp_d0 [1:20] = '{0,0,0,0, 0,1,2,3, 0,0, 1,2,3,4, 0,0,0,0,0,0};
    int exp_d3 [1:20] = '{0,0,0,0, 1023,0,1023,0, 0,0, 1023,0,1023,0, 0,0,0,0,0,0};

    cvm300_frame_emulator #(
        .LINE_PIXELS(4), .NUM_LINES(2), .LINE_GAP(2), .FOT_CYCLES(3)
    ) dut (
        .CLK_IN(clk), .SYS_RES_N(rst_n), .FRAME_REQ(req), .PATTERN_SEL(pat),
        .D(d_out), .Data_valid(dval), .Line_valid(lval), .busy(bsy),
        .frame_count(fcnt), .req_missed(missed)
    );

    cvm300_frame_emulator #(
        .LINE_PIXELS(1), .NUM_LINES(1), .LINE_GAP(1), .FOT_CYCLES(1)
    ) dut_s (
        .CLK_IN(clk), .SYS_RES_N(rst_n), .FRAME_REQ(req_s), .PATTERN_SEL(2'd1),
        .D(d_s), .Data_valid(dval_s), .Line_valid(lval_s), .busy(bsy_s),
        .frame_count(fcnt_s), .req_missed(missed_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Pulse FRAME_REQ for one cycle and record 20 cycles of outputs;
    // optionally pulse again at sample index second_at.
    task automatic capture(input logic [1:0] p, input int second_at);
        pat = p;
        @(negedge clk);
        req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            cap_lv[k] = lval;
            cap_dv[k] = dval;
            cap_d[k]  = d_out;
            cap_bz[k] = bsy;
            cap_fc[k] = fcnt;
            if (k == 1) req = 1'b0;
            if (second_at != 0 && k == second_at)     req = 1'b1;
            if (second_at != 0 && k == second_at + 1) req = 1'b0;
        end
    endtask

    task automatic test_reset();
        int busy_cycles;
        rst_n = 1'b0;
        req   = 1'b1;
        req_s = 1'b0;
        pat   = 2'd0;
        repeat (3) @(negedge clk);
        checks++; if (d_out !== 10'd0) begin errors++; $display("FAIL reset_d: got %0h expected 0", d_out); end
        checks++; if (dval !== 1'b0) begin errors++; $display("FAIL reset_dval: got %b expected 0", dval); end
        checks++; if (lval !== 1'b0) begin errors++; $display("FAIL reset_lval: got %b expected 0", lval); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bsy); end
        checks++; if (fcnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt: got %0h expected 0", fcnt); end
        checks++; if (missed !== 1'b0) begin errors++; $display("FAIL reset_missed: got %b expected 0", missed); end
        // Request held high across reset release must not start a frame
        rst_n = 1'b1;
        busy_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bsy === 1'b1 || lval === 1'b1) busy_cycles++;
        end
        checks++; if (busy_cycles !== 0) begin errors++; $display("FAIL held_over_reset: got %0d active cycles expected 0", busy_cycles); end
        req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_timing();
        capture(2'd0, 0);
        for (int k = 1; k <= 20; k++) begin
            logic exp_v;
            exp_v = (k >= 5 && k <= 8) || (k >= 11 && k <= 14);
            checks++; if (cap_lv[k] !== exp_v) begin errors++; $display("FAIL basic_lval[%0d]: got %b expected %b", k, cap_lv[k], exp_v); end
            checks++; if (cap_dv[k] !== exp_v) begin errors++; $display("FAIL basic_dval[%0d]: got %b expected %b", k, cap_dv[k], exp_v); end
            checks++; if (cap_d[k] !== 10'(exp_d0[k])) begin errors++; $display("FAIL basic_d[%0d]: got %0h expected %0h", k, cap_d[k], exp_d0[k]); end
            checks++; if (cap_bz[k] !== (k <= 15)) begin errors++; $display("FAIL basic_busy[%0d]: got %b expected %b", k, cap_bz[k], (k <= 15)); end
        end
        checks++; if (cap_fc[14] !== 16'd0) begin errors++; $display("FAIL basic_fcnt_before: got %0h expected 0", cap_fc[14]); end
        checks++; if (cap_fc[15] !== 16'd1) begin errors++; $display("FAIL basic_fcnt_after: got %0h expected 1", cap_fc[15]); end
        checks++; if (missed !== 1'b0) begin errors++; $display("FAIL basic_missed: got %b expected 0", missed); end
    endtask

    task automatic test_pattern3();
        capture(2'd3, 0);
        for (int k = 1; k <= 20; k++) begin
            checks++; if (cap_d[k] !== 10'(exp_d3[k])) begin errors++; $display("FAIL pat3_d[%0d]: got %0h expected %0h", k, cap_d[k], exp_d3[k]); end
        end
        checks++; if (cap_fc[20] !== 16'd2) begin errors++; $display("FAIL pat3_fcnt: got %0h expected 2", cap_fc[20]); end
    endtask

    task automatic test_missed_request();
        do_reset();
        capture(2'd0, 6);
        for (int k = 1; k <= 20; k++) begin
            logic exp_v;
            exp_v = (k >= 5 && k <= 8) || (k >= 11 && k <= 14);
            checks++; if (cap_lv[k] !== exp_v) begin errors++; $display("FAIL miss_lval[%0d]: got %b expected %b", k, cap_lv[k], exp_v); end
            checks++; if (cap_d[k] !== 10'(exp_d0[k])) begin errors++; $display("FAIL miss_d[%0d]: got %0h expected %0h", k, cap_d[k], exp_d0[k]); end
        end
        checks++; if (missed !== 1'b1) begin errors++; $display("FAIL miss_flag: got %b expected 1", missed); end
        checks++; if (cap_fc[20] !== 16'd1) begin errors++; $display("FAIL miss_fcnt: got %0h expected 1", cap_fc[20]); end
        // Edge in the cycle the sequencer returns to IDLE is also dropped
        do_reset();
        capture(2'd0, 15);
        checks++; if (missed !== 1'b1) begin errors++; $display("FAIL idle_return_missed: got %b expected 1", missed); end
        for (int k = 16; k <= 20; k++) begin
            checks++; if (cap_bz[k] !== 1'b0) begin errors++; $display("FAIL idle_return_busy[%0d]: got %b expected 0", k, cap_bz[k]); end
        end
        checks++; if (cap_fc[20] !== 16'd1) begin errors++; $display("FAIL idle_return_fcnt: got %0h expected 1", cap_fc[20]); end
    endtask

    task automatic test_held_request();
        int npix;
        do_reset();
        pat  = 2'd2;
        npix = 0;
        @(negedge clk);
        req = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (dval === 1'b1) begin
                npix++;
                checks++; if (d_out !== 10'd0) begin errors++; $display("FAIL held_f1_d[%0d]: got %0h expected 0", k, d_out); end
            end
            if (k == 20) req = 1'b0;
        end
        checks++; if (npix !== 8) begin errors++; $display("FAIL held_pixels: got %0d expected 8", npix); end
        checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL held_fcnt1: got %0h expected 1", fcnt); end
        checks++; if (missed !== 1'b0) begin errors++; $display("FAIL held_missed: got %b expected 0", missed); end
        capture(2'd2, 0);
        npix = 0;
        for (int k = 1; k <= 20; k++) begin
            if (cap_dv[k] === 1'b1) begin
                npix++;
                checks++; if (cap_d[k] !== 10'd1) begin errors++; $display("FAIL held_f2_d[%0d]: got %0h expected 1", k, cap_d[k]); end
            end
        end
        checks++; if (npix !== 8) begin errors++; $display("FAIL held_f2_pixels: got %0d expected 8", npix); end
        checks++; if (cap_fc[20] !== 16'd2) begin errors++; $display("FAIL held_fcnt2: got %0h expected 2", cap_fc[20]); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        pat = 2'd0;
        @(negedge clk);
        req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req = 1'b0;
            if (k == 6) req = 1'b1;
            if (k == 7) req = 1'b0;
        end
        checks++; if (lval !== 1'b1 || d_out !== 10'd2) begin errors++; $display("FAIL mid_pre_pixel: got lval %b d %0h expected lval 1 d 2", lval, d_out); end
        checks++; if (missed !== 1'b1) begin errors++; $display("FAIL mid_pre_missed: got %b expected 1", missed); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (dval !== 1'b0) begin errors++; $display("FAIL mid_dval: got %b expected 0", dval); end
        checks++; if (lval !== 1'b0) begin errors++; $display("FAIL mid_lval: got %b expected 0", lval); end
        checks++; if (d_out !== 10'd0) begin errors++; $display("FAIL mid_d: got %0h expected 0", d_out); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bsy); end
        checks++; if (fcnt !== 16'd0) begin errors++; $display("FAIL mid_fcnt: got %0h expected 0", fcnt); end
        checks++; if (missed !== 1'b0) begin errors++; $display("FAIL mid_missed: got %b expected 0", missed); end
        rst_n = 1'b1;
        @(negedge clk);
        capture(2'd0, 0);
        for (int k = 1; k <= 20; k++) begin
            logic exp_v;
            exp_v = (k >= 5 && k <= 8) || (k >= 11 && k <= 14);
            checks++; if (cap_dv[k] !== exp_v) begin errors++; $display("FAIL mid_new_dval[%0d]: got %b expected %b", k, cap_dv[k], exp_v); end
            checks++; if (cap_d[k] !== 10'(exp_d0[k])) begin errors++; $display("FAIL mid_new_d[%0d]: got %0h expected %0h", k, cap_d[k], exp_d0[k]); end
        end
        checks++; if (cap_fc[20] !== 16'd1) begin errors++; $display("FAIL mid_new_fcnt: got %0h expected 1", cap_fc[20]); end
    endtask

    // 1x1 frames at the shortest accepted request spacing (5 cycles)
    task automatic test_frame_count_wrap();
        for (int i = 1; i <= 65536; i++) begin
            req_s = 1'b1;
            @(negedge clk);
            req_s = 1'b0;
            repeat (4) @(negedge clk);
            if (i == 1) begin
                checks++; if (fcnt_s !== 16'd1) begin errors++; $display("FAIL wrap_first: got %0h expected 1", fcnt_s); end
            end
            if (i == 65535) begin
                checks++; if (fcnt_s !== 16'hFFFF) begin errors++; $display("FAIL wrap_max: got %0h expected ffff", fcnt_s); end
            end
        end
        checks++; if (fcnt_s !== 16'd0) begin errors++; $display("FAIL wrap_zero: got %0h expected 0", fcnt_s); end
        checks++; if (missed_s !== 1'b0) begin errors++; $display("FAIL wrap_missed: got %b expected 0", missed_s); end
        checks++; if (bsy_s !== 1'b0) begin errors++; $display("FAIL wrap_busy: got %b expected 0", bsy_s); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_timing();
        test_pattern3();
        test_missed_request();
        test_held_request();
        test_reset_midframe();
        test_frame_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
